// File: rtl/inv_pkg.sv
// Shared FSM state codes and saturating fixed-point helpers for the Gauss-Jordan inverter.
package inv_pkg;

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_LOAD  = 4'd1;
  localparam logic [3:0] S_PIVOT = 4'd2;
  localparam logic [3:0] S_SWAP  = 4'd3;
  localparam logic [3:0] S_RECIP = 4'd4;
  localparam logic [3:0] S_NORM  = 4'd5;
  localparam logic [3:0] S_ELIM  = 4'd6;
  localparam logic [3:0] S_DONE  = 4'd7;
  localparam logic [3:0] S_OUT   = 4'd8;

  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  function automatic logic signed [63:0] sat_w(input logic signed [63:0] x, input int w);
    if (x > sat_max(w)) return sat_max(w);
    if (x < sat_min(w)) return sat_min(w);
    return x;
  endfunction

  // Arithmetic shift floors the product (toward -inf) before clamping to w bits.
  function automatic logic signed [63:0] fxmul(input logic signed [63:0] a,
                                               input logic signed [63:0] b,
                                               input int frac, input int w);
    logic signed [63:0] p;
    p = (a * b) >>> frac;
    return sat_w(p, w);
  endfunction

endpackage

// File: rtl/fx_recip_div.sv
// Sequential signed restoring divider: one quotient bit per cycle on magnitudes,
// sign applied and result saturated to DATA_W at the output.
module fx_recip_div
  import inv_pkg::*;
#(
  parameter int DATA_W = 17,
  parameter int FRAC_W = 8,
  parameter int QW     = DATA_W + FRAC_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic signed [QW-1:0]     num,
  input  logic signed [DATA_W-1:0] den,
  output logic                     done,
  output logic signed [DATA_W-1:0] quot
);

  localparam int CNTW = $clog2(QW + 1);

  logic              busy_q, busy_d, done_q, done_d, neg_q, neg_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [QW-1:0]     num_q, num_d, quo_q, quo_d;
  logic [DATA_W-1:0] den_q, den_d, rem_q, rem_d;
  logic [DATA_W:0]   rem_sh;
  logic              ge;
  logic signed [63:0] qm, qs;

  always_comb begin
    busy_d = busy_q;
    done_d = 1'b0;
    neg_d  = neg_q;
    cnt_d  = cnt_q;
    num_d  = num_q;
    den_d  = den_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    // Remainder stays below the divisor magnitude, so DATA_W+1 bits hold the shifted value.
    rem_sh = {rem_q, num_q[QW-1]};
    ge     = rem_sh >= {1'b0, den_q};
    if (start) begin
      num_d  = num[QW-1] ? $unsigned(-num) : $unsigned(num);
      den_d  = den[DATA_W-1] ? $unsigned(-den) : $unsigned(den);
      neg_d  = num[QW-1] ^ den[DATA_W-1];
      rem_d  = '0;
      quo_d  = '0;
      cnt_d  = CNTW'(QW);
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d = DATA_W'(ge ? rem_sh - {1'b0, den_q} : rem_sh);
      quo_d = {quo_q[QW-2:0], ge};
      num_d = num_q << 1;
      cnt_d = cnt_q - CNTW'(1);
      if (cnt_q == CNTW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_comb begin
    qm   = $signed(64'(quo_q));
    qs   = neg_q ? -qm : qm;
    quot = DATA_W'(sat_w(qs, DATA_W));
  end

  assign done = done_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    neg_q <= neg_d;
    num_q <= num_d;
    den_q <= den_d;
    rem_q <= rem_d;
    quo_q <= quo_d;
  end

endmodule

// File: rtl/matrix_inv_gj.sv
// Sequential N x N Gauss-Jordan inverter with partial pivoting on Q(DATA_W-FRAC_W).FRAC_W data,
// streamed row-major in and out, single shared multiplier and a bit-serial reciprocal.
module matrix_inv_gj
  import inv_pkg::*;
#(
  parameter int N      = 5,
  parameter int DATA_W = 17,
  parameter int FRAC_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic              singular
);

  localparam int RW = $clog2(N);
  localparam int CW = RW + 1;
  localparam int QW = DATA_W + FRAC_W;
  typedef logic signed [DATA_W-1:0] elem_t;
  localparam elem_t            ONE       = elem_t'(1 << FRAC_W);
  localparam logic [RW-1:0]    LAST_R    = RW'(N - 1);
  localparam logic [CW-1:0]    LAST_C    = CW'(2 * N - 1);
  localparam logic [CW-1:0]    LAST_H    = CW'(N - 1);
  localparam logic signed [QW-1:0] RECIP_NUM = QW'(1) << (2 * FRAC_W);

  elem_t a_q [N][2*N];
  elem_t a_d [N][2*N];
  logic [3:0]        state_q, state_d;
  logic [RW-1:0]     row_q, row_d, k_q, k_d, piv_q, piv_d;
  logic [CW-1:0]     col_q, col_d, nr, ocol;
  logic              cap_q, cap_d, rstart_q, rstart_d, sing_q, sing_d;
  elem_t             f_q, f_d, recip_q, recip_d;
  logic [DATA_W-1:0] max_q, max_d, mag;
  elem_t             pv, mul_a, mul_b, prod, diff, div_q;
  logic              div_start, div_done, elim_last;

  fx_recip_div #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_recip (
    .clk   (clk),
    .rst_n (rst_n),
    .start (div_start),
    .num   (RECIP_NUM),
    .den   (a_q[k_q][{1'b0, k_q}]),
    .done  (div_done),
    .quot  (div_q)
  );

  assign div_start = (state_q == S_RECIP) && !rstart_q;

  // NORM scales the pivot row by the reciprocal; ELIM reuses the same multiplier for f * pivot-row.
  always_comb begin
    pv    = a_q[row_q][{1'b0, k_q}];
    mag   = pv[DATA_W-1] ? $unsigned(-pv) : $unsigned(pv);
    mul_a = f_q;
    mul_b = a_q[k_q][col_q];
    if (state_q == S_NORM) begin
      mul_a = a_q[k_q][col_q];
      mul_b = recip_q;
    end
    prod = elem_t'(fxmul(64'(mul_a), 64'(mul_b), FRAC_W, DATA_W));
    diff = elem_t'(sat_w(64'(a_q[row_q][col_q]) - 64'(prod), DATA_W));
    nr   = {1'b0, row_q} + CW'(1);
    if (nr == {1'b0, k_q}) nr = nr + CW'(1);
    elim_last = nr >= CW'(N);
  end

  always_comb begin
    state_d = state_q;  row_d = row_q;  col_d = col_q;  k_d = k_q;
    cap_d = cap_q;  rstart_d = rstart_q;  sing_d = sing_q;
    a_d = a_q;  f_d = f_q;  recip_d = recip_q;  max_d = max_q;  piv_d = piv_q;
    case (state_q)
      S_IDLE, S_LOAD: if (in_valid) begin
        if (state_q == S_IDLE) begin
          sing_d = 1'b0;
          for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
              a_d[r][c+N] = (r == c) ? ONE : '0;
        end
        a_d[row_q][col_q] = elem_t'(in_data);
        state_d = S_LOAD;
        if (col_q == LAST_H) begin
          col_d = '0;
          row_d = row_q + RW'(1);
          if (row_q == LAST_R) begin
            row_d = '0;  k_d = '0;  piv_d = '0;  max_d = '0;
            state_d = S_PIVOT;
          end
        end else col_d = col_q + CW'(1);
      end
      S_PIVOT: begin
        if (row_q >= k_q && mag > max_q) begin
          max_d = mag;
          piv_d = row_q;
        end
        row_d = row_q + RW'(1);
        if (row_q == LAST_R) begin
          row_d = '0;
          if (max_d == '0) begin
            sing_d  = 1'b1;
            state_d = S_DONE;
          end else state_d = S_SWAP;
        end
      end
      S_SWAP: begin
        for (int c = 0; c < 2 * N; c++) begin
          a_d[k_q][c]   = a_q[piv_q][c];
          a_d[piv_q][c] = a_q[k_q][c];
        end
        rstart_d = 1'b0;
        state_d  = S_RECIP;
      end
      S_RECIP: begin
        rstart_d = 1'b1;
        if (div_done) begin
          recip_d = div_q;
          col_d   = '0;
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        a_d[k_q][col_q] = prod;
        col_d = col_q + CW'(1);
        if (col_q == LAST_C) begin
          col_d   = '0;
          row_d   = (k_q == '0) ? RW'(1) : '0;
          cap_d   = 1'b1;
          state_d = S_ELIM;
        end
      end
      S_ELIM: if (cap_q) begin
        f_d   = a_q[row_q][{1'b0, k_q}];
        cap_d = 1'b0;
      end else begin
        a_d[row_q][col_q] = diff;
        col_d = col_q + CW'(1);
        if (col_q == LAST_C) begin
          col_d = '0;
          cap_d = 1'b1;
          row_d = nr[RW-1:0];
          if (elim_last) begin
            row_d = '0;
            if (k_q == LAST_R) state_d = S_DONE;
            else begin
              k_d = k_q + RW'(1);  piv_d = k_q + RW'(1);  max_d = '0;
              state_d = S_PIVOT;
            end
          end
        end
      end
      S_DONE: begin
        row_d   = '0;
        col_d   = '0;
        state_d = sing_q ? S_IDLE : S_OUT;
      end
      S_OUT: if (out_ready) begin
        col_d = col_q + CW'(1);
        if (col_q == LAST_H) begin
          col_d = '0;
          row_d = row_q + RW'(1);
          if (row_q == LAST_R) begin
            row_d   = '0;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ocol      = col_q + CW'(N);
    in_ready  = (state_q == S_IDLE) || (state_q == S_LOAD);
    out_valid = (state_q == S_OUT);
    out_data  = (state_q == S_OUT) ? a_q[row_q][ocol] : '0;
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    singular  = sing_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      row_q    <= '0;
      col_q    <= '0;
      k_q      <= '0;
      cap_q    <= 1'b0;
      rstart_q <= 1'b0;
      sing_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      k_q      <= k_d;
      cap_q    <= cap_d;
      rstart_q <= rstart_d;
      sing_q   <= sing_d;
    end
  end

  always_ff @(posedge clk) begin
    a_q     <= a_d;
    f_q     <= f_d;
    recip_q <= recip_d;
    max_q   <= max_d;
    piv_q   <= piv_d;
  end

endmodule
